// File: rtl/matrix_op_sequencer.sv
// Byte-serial load / execute / store sequencer for the element-wise matrix units.
// Defining MATRIX_SEQ_ABORT_EN adds an abort input that cancels a running command.
module matrix_op_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int ELEM_MAX = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
`ifdef MATRIX_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [1:0]            opcode,
  input  logic [1:0]            matrix_size,
  input  logic [ADDR_W-1:0]     base_a,
  input  logic [ADDR_W-1:0]     base_b,
  input  logic [ADDR_W-1:0]     base_r,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_rdata,
  output logic                  mem_wr,
  output logic [7:0]            mem_wdata,
  output logic [ELEM_MAX*8-1:0] matrix_a,
  output logic [ELEM_MAX*8-1:0] matrix_b,
  output logic [1:0]            op_sel,
  output logic [1:0]            dp_size,
  input  logic [ELEM_MAX*8-1:0] result_in,
  input  logic                  overflow_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(ELEM_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, EXEC, STORE, DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nx;
  logic [CNT_W-1:0]     n;
  logic [ADDR_W-1:0]    base_a_q;
  logic [ADDR_W-1:0]    base_b_q;
  logic [ADDR_W-1:0]    base_r_q;
  logic [ELEM_MAX*8-1:0] res;
  logic                 abort_hit;

  always_comb begin
    n = CNT_W'(4);
    unique case (dp_size)
      2'b00: n = CNT_W'(4);
      2'b01: n = CNT_W'(9);
      2'b10: n = CNT_W'(16);
      2'b11: n = CNT_W'(25);
    endcase
  end

  assign cnt_nx = cnt + CNT_W'(1);
  assign busy   = (state != IDLE);

`ifdef MATRIX_SEQ_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Load phases run N+1 cycles: address k goes out in cycle k,
  // its byte lands in cycle k+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      base_a_q  <= '0;
      base_b_q  <= '0;
      base_r_q  <= '0;
      res       <= '0;
      matrix_a  <= '0;
      matrix_b  <= '0;
      op_sel    <= '0;
      dp_size   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        state    <= IDLE;
        mem_rd   <= 1'b0;
        mem_wr   <= 1'b0;
        overflow <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              op_sel   <= opcode;
              dp_size  <= matrix_size;
              base_a_q <= base_a;
              base_b_q <= base_b;
              base_r_q <= base_r;
              matrix_a <= '0;
              matrix_b <= '0;
              overflow <= 1'b0;
              mem_rd   <= 1'b1;
              mem_addr <= base_a;
              cnt      <= '0;
              state    <= LOAD_A;
            end
          end
          LOAD_A: begin
            if (cnt != '0)
              matrix_a[8*(int'(cnt)-1) +: 8] <= mem_rdata;
            if (cnt == n) begin
              cnt      <= '0;
              mem_rd   <= 1'b1;
              mem_addr <= base_b_q;
              state    <= LOAD_B;
            end else begin
              cnt      <= cnt_nx;
              mem_rd   <= (cnt_nx != n);
              mem_addr <= base_a_q + ADDR_W'(cnt_nx);
            end
          end
          LOAD_B: begin
            if (cnt != '0)
              matrix_b[8*(int'(cnt)-1) +: 8] <= mem_rdata;
            if (cnt == n) begin
              cnt   <= '0;
              state <= EXEC;
            end else begin
              cnt      <= cnt_nx;
              mem_rd   <= (cnt_nx != n);
              mem_addr <= base_b_q + ADDR_W'(cnt_nx);
            end
          end
          EXEC: begin
            res       <= result_in;
            overflow  <= overflow_in;
            cnt       <= '0;
            mem_wr    <= 1'b1;
            mem_addr  <= base_r_q;
            mem_wdata <= result_in[7:0];
            state     <= STORE;
          end
          STORE: begin
            if (cnt_nx == n) begin
              mem_wr <= 1'b0;
              state  <= DONE;
            end else begin
              cnt       <= cnt_nx;
              mem_addr  <= base_r_q + ADDR_W'(cnt_nx);
              mem_wdata <= res[8*int'(cnt_nx) +: 8];
            end
          end
          DONE: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed vector bench for matrix_op_sequencer with memory and datapath models.
// Abort sequence is included when MATRIX_SEQ_ABORT_EN is defined.
module tb_matrix_op_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   opcode;
  logic [1:0]   matrix_size;
  logic [7:0]   base_a, base_b, base_r;
  logic [7:0]   mem_addr, mem_rdata, mem_wdata;
  logic         mem_rd, mem_wr;
  logic [199:0] matrix_a, matrix_b, result_in;
  logic [1:0]   op_sel, dp_size;
  logic         overflow_in, busy, done, overflow;
`ifdef MATRIX_SEQ_ABORT_EN
  logic         abort;
`endif

  matrix_op_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef MATRIX_SEQ_ABORT_EN
    .abort(abort),
`endif
    .opcode(opcode), .matrix_size(matrix_size),
    .base_a(base_a), .base_b(base_b), .base_r(base_r),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .matrix_a(matrix_a), .matrix_b(matrix_b),
    .op_sel(op_sel), .dp_size(dp_size),
    .result_in(result_in), .overflow_in(overflow_in),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] size;
    logic [1:0] op;
    logic [7:0] ba, bb, br;
    logic [7:0] a0, as, b0, bs;
    logic       spam;
    int         lat;
    logic       ovf;
    logic [7:0] r0;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] mem [256];
  logic [7:0] rd_log [64];
  int rd_n, wr_n, done_n, cyc;
  int n_checks, n_fail;

  // byte-wide memory: write on the strobe edge, read data one cycle later
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] = mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    cyc++;
    if (mem_rd) begin
      if (rd_n < 64) rd_log[rd_n] = mem_addr;
      rd_n++;
    end
    if (mem_wr) wr_n++;
    if (done) done_n++;
    if (mem_rd || mem_wr) begin
      n_checks++;
      if (mem_rd && mem_wr) begin
        n_fail++;
        $display("FAIL rd_wr_excl: both strobes high at cycle %0d", cyc);
      end
    end
  end

  function automatic logic [8:0] dp_elem(
    input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic [7:0] r;
    logic       v;
    r = sub ? a - b : a + b;
    v = sub ? (a[7] != b[7]) && (r[7] != a[7])
            : (a[7] == b[7]) && (r[7] != a[7]);
    return {v, r};
  endfunction

  always_comb begin
    logic [8:0] e;
    result_in   = '0;
    overflow_in = 1'b0;
    for (int i = 0; i < 25; i++) begin
      e = dp_elem(matrix_a[8*i +: 8], matrix_b[8*i +: 8], op_sel == 2'b01);
      result_in[8*i +: 8] = e[7:0];
      overflow_in = overflow_in | e[8];
    end
  end

  function automatic int elems(input logic [1:0] s);
    case (s)
      2'b00: return 4;
      2'b01: return 9;
      2'b10: return 16;
      default: return 25;
    endcase
  endfunction

  function automatic vec_t mk(
    input logic [1:0] size, input logic [1:0] op,
    input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] br,
    input logic [7:0] a0, input logic [7:0] as,
    input logic [7:0] b0, input logic [7:0] bs,
    input logic spam, input int lat, input logic ovf, input logic [7:0] r0);
    vec_t v;
    v.size = size; v.op = op; v.ba = ba; v.bb = bb; v.br = br;
    v.a0 = a0; v.as = as; v.b0 = b0; v.bs = bs;
    v.spam = spam; v.lat = lat; v.ovf = ovf; v.r0 = r0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] a_k(input vec_t v, input int k);
    return v.a0 + 8'(k) * v.as;
  endfunction

  function automatic logic [7:0] b_k(input vec_t v, input int k);
    return v.b0 + 8'(k) * v.bs;
  endfunction

  task automatic launch(input vec_t v, output int t0);
    int n;
    n = elems(v.size);
    for (int k = 0; k < n; k++) begin
      mem[v.ba + 8'(k)] = a_k(v, k);
      mem[v.bb + 8'(k)] = b_k(v, k);
      mem[v.br + 8'(k)] = 8'hEE;
    end
    @(negedge clk);
    rd_n = 0; wr_n = 0; done_n = 0;
    opcode = v.op; matrix_size = v.size;
    base_a = v.ba; base_b = v.bb; base_r = v.br;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int n, t0, t, lat, bad;
    logic [199:0] exp_a, exp_b;
    logic [8:0]   e;
    logic [7:0]   ea;
    n = elems(v.size);
    exp_a = '0; exp_b = '0;
    for (int k = 0; k < n; k++) begin
      exp_a[8*k +: 8] = a_k(v, k);
      exp_b[8*k +: 8] = b_k(v, k);
    end
    launch(v, t0);
    chk({tag, "_ovf_cleared"}, {31'd0, overflow}, 32'd0);
    lat = -1;
    for (int c = 0; c < 120 && lat < 0; c++) begin
      @(negedge clk);
      t = cyc - t0;
      start = 1'b0;
      if (t == 2*n + 2) begin
        n_checks++;
        if (matrix_a !== exp_a || matrix_b !== exp_b) begin
          n_fail++;
          $display("FAIL %s_buses: a=%h b=%h expected a=%h b=%h",
                   tag, matrix_a, matrix_b, exp_a, exp_b);
        end
        chk({tag, "_op_sel"}, {30'd0, op_sel}, {30'd0, v.op});
        chk({tag, "_dp_size"}, {30'd0, dp_size}, {30'd0, v.size});
      end
      if (done) lat = t;
      else if (v.spam && busy && t[0]) start = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, v.ovf});
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_reads"}, rd_n, 2*n);
    chk({tag, "_writes"}, wr_n, n);
    bad = 0;
    for (int k = 0; k < 2*n; k++) begin
      ea = (k < n) ? v.ba + 8'(k) : v.bb + 8'(k - n);
      if (rd_log[k] !== ea) bad++;
    end
    chk({tag, "_rd_addr_errs"}, bad, 0);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      e = dp_elem(a_k(v, k), b_k(v, k), v.op == 2'b01);
      if (mem[v.br + 8'(k)] !== e[7:0]) bad++;
    end
    chk({tag, "_result_errs"}, bad, 0);
    chk({tag, "_r0"}, {24'd0, mem[v.br]}, {24'd0, v.r0});
  endtask

  initial begin
    int t0, c;
    n_checks = 0; n_fail = 0; cyc = 0;
    rd_n = 0; wr_n = 0; done_n = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    reset = 1'b1; start = 1'b0; opcode = '0; matrix_size = '0;
    base_a = '0; base_b = '0; base_r = '0;
`ifdef MATRIX_SEQ_ABORT_EN
    abort = 1'b0;
`endif

    //        size   op     ba     bb     br     a0     as    b0     bs  spam lat ovf r0
    vecs[0] = mk(2'd0, 2'd1, 8'h00, 8'h10, 8'h20, 8'd10, 8'd10, 8'd1,  8'd1, 0, 16, 0, 8'd9);
    vecs[1] = mk(2'd3, 2'd0, 8'h40, 8'h60, 8'h80, 8'h67, 8'd1,  8'd1,  8'd0, 0, 79, 1, 8'h68);
    vecs[2] = mk(2'd1, 2'd0, 8'h30, 8'h20, 8'h10, 8'd1,  8'd2,  8'd100, 8'd1, 1, 31, 0, 8'd101);
    vecs[3] = mk(2'd0, 2'd0, 8'hFE, 8'h10, 8'h50, 8'd5,  8'd5,  8'h20, 8'd0, 0, 16, 0, 8'h25);
    vecs[4] = mk(2'd0, 2'd2, 8'h60, 8'h70, 8'h80, 8'h7F, 8'd0,  8'h80, 8'd0, 0, 16, 0, 8'hFF);
    vecs[5] = mk(2'd0, 2'd1, 8'h60, 8'h70, 8'h80, 8'h80, 8'd0,  8'h01, 8'd0, 0, 16, 1, 8'h7F);
    vecs[6] = mk(2'd2, 2'd1, 8'hA0, 8'hC0, 8'hE0, 8'h50, 8'd3,  8'h10, 8'd1, 0, 52, 0, 8'h40);

    repeat (2) @(negedge clk);
    chk("rst_strobes", {27'd0, mem_rd, mem_wr, busy, done, overflow}, 32'd0);
    chk("rst_addr_data", {16'd0, mem_addr, mem_wdata}, 32'd0);
    chk("rst_sel_size", {28'd0, op_sel, dp_size}, 32'd0);
    chk("rst_buses_zero", {31'd0, |{matrix_a, matrix_b}}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_cmd(vecs[i], $sformatf("v%0d", i));

    // async reset in the middle of a 4x4 store
    launch(vecs[6], t0);
    c = 0;
    while (wr_n < 5 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("mid_rst_reached", wr_n, 5);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_strobes", {27'd0, mem_rd, mem_wr, busy, done, overflow}, 32'd0);
    chk("mid_rst_addr_data", {16'd0, mem_addr, mem_wdata}, 32'd0);
    chk("mid_rst_buses_zero", {31'd0, |{matrix_a, matrix_b}}, 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_no_more_wr", wr_n, 5);
    reset = 1'b0;
    run_cmd(vecs[6], "after_rst");

`ifdef MATRIX_SEQ_ABORT_EN
    begin
      logic [199:0] exp_a;
      exp_a = '0;
      for (int k = 0; k < 9; k++) exp_a[8*k +: 8] = a_k(vecs[2], k);
      launch(vecs[2], t0);
      while (cyc - t0 < 12) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_idle", {29'd0, busy, mem_rd, mem_wr}, 32'd0);
      chk("abort_ovf", {31'd0, overflow}, 32'd0);
      chk("abort_a_kept", {31'd0, matrix_a === exp_a}, 32'd1);
      repeat (5) @(negedge clk);
      chk("abort_no_done", done_n, 0);
      chk("abort_no_wr", wr_n, 0);
      run_cmd(vecs[0], "after_abort");
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/matrix_op_sequencer.md
Name: matrix_op_sequencer

Overview:
Controller for the coprocessor's combinational element-wise matrix units (add/subtract). It accepts one command, fetches matrices A and B byte-by-byte from a byte-wide data memory, and presents them as packed 200-bit buses for one execute cycle. It captures the packed result and overflow flag, writes the active result elements back to memory, and signals completion. It sits between the instruction decode/host interface and the matrix datapath.

Parameters:
ADDR_W, 8, width of the memory byte address.
ELEM_MAX, 25, maximum element count (5x5); packed buses are ELEM_MAX*8 bits.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  command strobe; sampled only in IDLE.
opcode  input  2  operation select forwarded to datapath: 00 add, 01 subtract, 10/11 reserved (executed as add).
matrix_size  input  2  00=2x2 (4), 01=3x3 (9), 10=4x4 (16), 11=5x5 (25 elements).
base_a  input  ADDR_W  byte address of A element 0.
base_b  input  ADDR_W  byte address of B element 0.
base_r  input  ADDR_W  byte address of result element 0.
mem_addr  output  ADDR_W  memory address.
mem_rd  output  1  read strobe; data returns on mem_rdata exactly 1 cycle later.
mem_rdata  input  8  read data.
mem_wr  output  1  write strobe; write happens on the same edge.
mem_wdata  output  8  write data.
matrix_a  output  200  packed A to datapath, element i at bits [i*8+:8], row-major.
matrix_b  output  200  packed B to datapath, same packing.
op_sel  output  2  latched opcode to datapath.
dp_size  output  2  latched matrix_size to datapath.
result_in  input  200  packed datapath result.
overflow_in  input  1  datapath overflow flag.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse at end of command.
overflow  output  1  sticky overflow of the last command.

Behaviour:
- Reset (async): state IDLE; matrix_a, matrix_b, internal result register, op_sel, dp_size, mem_addr, mem_wdata = 0; mem_rd, mem_wr, busy, done, overflow = 0.
- N = element count from the latched matrix_size.
- IDLE: start=1 latches opcode, size, and the three bases; clears matrix_a, matrix_b, and overflow to 0; moves to LOAD_A. start in any other state is ignored.
- LOAD_A: N+1 cycles.
  - Cycles 0..N-1: mem_rd=1, mem_addr=base_a+k.
  - Cycles 1..N: mem_rdata captured into matrix_a element k-1.
  - After the final capture, moves to LOAD_B.
- LOAD_B: same as LOAD_A using base_b into matrix_b; then EXEC.
- EXEC: 1 cycle. matrix_a, matrix_b, op_sel, and dp_size are stable. result_in is registered; overflow <= overflow_in. Then STORE.
- STORE: N cycles. mem_wr=1, mem_addr=base_r+k, mem_wdata=registered result element k. Then DONE.
- DONE: done=1 for one cycle; then IDLE. busy drops when IDLE is entered.
- Command latency: start edge to done high = 3N+4 cycles (2x2: 16; 5x5: 79).
- Elements with index >= N are never read or written and stay 0 on the packed buses.
- Address arithmetic is modulo 2^ADDR_W. Wrap-around is legal and not flagged.
- mem_rd and mem_wr are never high in the same cycle.
- Reset mid-command aborts immediately to the reset state. Memory writes already performed are not undone.
- Outputs are all registered except busy, which is decoded from state.

Optional Feature:
MATRIX_SEQ_ABORT_EN. When defined, adds input abort (1 bit). abort=1 in any non-IDLE state returns the block to IDLE on the next edge:
- no done pulse;
- mem_rd and mem_wr drop;
- overflow is cleared;
- packed buses keep their current contents.
In IDLE, abort has no effect, and start is still honoured if asserted together with it. When undefined, the port does not exist and commands always run to completion.

Test Plan:
- 2x2 subtract: mem[0..3]={10,20,30,40}, mem[16..19]={1,2,3,4}, base_a=0, base_b=16, base_r=32, opcode=01, datapath returns A-B -> mem[32..35]={9,18,27,36}; done exactly 16 cycles after start; overflow=0; matrix_a bits[199:32]=0.
- 5x5 add with one element 8'h7F+8'h01 -> overflow_in=1 in EXEC -> overflow=1 after done; 25 writes at base_r..base_r+24; done at cycle 79; overflow clears on next accepted start.
- start pulsed repeatedly while busy with a 3x3 command -> ignored; exactly 9 reads of A, 9 of B, 9 writes; single done pulse at cycle 31.
- Address wrap: ADDR_W=8, base_a=8'hFE, size 2x2 -> read addresses FE, FF, 00, 01; data packed in that order.
- Async reset asserted mid-STORE of a 4x4 command (after 5 writes) -> all outputs 0 immediately without a clock edge; no further mem_wr; the next start runs a full command.
- With MATRIX_SEQ_ABORT_EN: abort during LOAD_B -> IDLE next cycle, no done, no mem_wr ever asserted, overflow=0.
